// File: rtl/battle_turn_sequencer.sv
// Battle turn scheduler: collects player/AI moves, orders attacks by speed, shares one
// damage unit through a req/done handshake, and owns both HP registers and the end flags.
module battle_turn_sequencer #(
  parameter int HP_W    = 4,
  parameter int DMG_W   = 4,
  parameter int SPD_W   = 4,
  parameter int HP_INIT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             p_move_valid,
  input  logic [1:0]       p_move,
  output logic             p_move_ready,
  input  logic             ai_move_valid,
  input  logic [1:0]       ai_move,
  output logic             ai_move_ready,
  input  logic [SPD_W-1:0] p_speed,
  input  logic [SPD_W-1:0] ai_speed,
  output logic             dmg_req,
  output logic             dmg_attacker,
  output logic [1:0]       dmg_move,
  input  logic             dmg_done,
  input  logic [DMG_W-1:0] dmg_value,
  output logic [HP_W-1:0]  p_hp,
  output logic [HP_W-1:0]  ai_hp,
  output logic             victory,
  output logic             loss,
  output logic [7:0]       turn_count
);

  typedef enum logic [2:0] {
    S_COLLECT, S_WAIT1, S_APPLY1, S_WAIT2, S_APPLY2, S_VICTORY, S_LOSS
  } state_t;

  state_t            state_q, state_d;
  logic              p_lat_q, p_lat_d, ai_lat_q, ai_lat_d;
  logic [1:0]        p_move_q, p_move_d, ai_move_q, ai_move_d;
  logic              p_first_q, p_first_d;
  logic [DMG_W-1:0]  dmg_q, dmg_d;
  logic [HP_W-1:0]   p_hp_q, p_hp_d, ai_hp_q, ai_hp_d;
  logic [7:0]        turn_q, turn_d;

  logic              p_acc, ai_acc, both_held;
  logic              in_apply, victim_is_ai;
  logic [HP_W-1:0]   tgt_hp, new_hp;

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                              input logic [DMG_W-1:0] dmg);
    if (32'(dmg) >= 32'(hp)) sat_sub = '0;
    else                     sat_sub = hp - HP_W'(dmg);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    sat_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  // Handshake and attack-resolution terms shared by next-state and datapath logic
  always_comb begin
    p_acc        = (state_q == S_COLLECT) && !p_lat_q && p_move_valid;
    ai_acc       = (state_q == S_COLLECT) && !ai_lat_q && ai_move_valid;
    both_held    = (p_lat_q || p_acc) && (ai_lat_q || ai_acc);
    in_apply     = (state_q == S_APPLY1) || (state_q == S_APPLY2);
    victim_is_ai = (state_q == S_APPLY1) ? p_first_q : !p_first_q;
    tgt_hp       = victim_is_ai ? ai_hp_q : p_hp_q;
    new_hp       = sat_sub(tgt_hp, dmg_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_COLLECT;
      p_lat_q  <= 1'b0;
      ai_lat_q <= 1'b0;
      p_hp_q   <= HP_W'(HP_INIT);
      ai_hp_q  <= HP_W'(HP_INIT);
      turn_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      p_lat_q  <= p_lat_d;
      ai_lat_q <= ai_lat_d;
      p_hp_q   <= p_hp_d;
      ai_hp_q  <= ai_hp_d;
      turn_q   <= turn_d;
    end
  end

  always_ff @(posedge clk) begin
    p_move_q  <= p_move_d;
    ai_move_q <= ai_move_d;
    p_first_q <= p_first_d;
    dmg_q     <= dmg_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COLLECT: if (both_held) state_d = S_WAIT1;
      S_WAIT1:   if (dmg_done) state_d = S_APPLY1;
      S_WAIT2:   if (dmg_done) state_d = S_APPLY2;
      S_APPLY1, S_APPLY2: begin
        if (new_hp == '0)             state_d = victim_is_ai ? S_VICTORY : S_LOSS;
        else if (state_q == S_APPLY1) state_d = S_WAIT2;
        else                          state_d = S_COLLECT;
      end
      default: state_d = state_q;
    endcase
  end

  // Move latches, speed order, damage capture, HP and turn counter
  always_comb begin
    p_lat_d   = p_lat_q || p_acc;
    ai_lat_d  = ai_lat_q || ai_acc;
    p_move_d  = p_acc ? p_move : p_move_q;
    ai_move_d = ai_acc ? ai_move : ai_move_q;
    p_first_d = p_first_q;
    dmg_d     = dmg_q;
    p_hp_d    = p_hp_q;
    ai_hp_d   = ai_hp_q;
    turn_d    = turn_q;
    if (state_q == S_COLLECT && both_held) p_first_d = (p_speed >= ai_speed);
    if ((state_q == S_WAIT1 || state_q == S_WAIT2) && dmg_done) dmg_d = dmg_value;
    if (in_apply) begin
      if (victim_is_ai) ai_hp_d = new_hp;
      else              p_hp_d  = new_hp;
      if (state_q == S_APPLY2 && new_hp != '0) begin
        turn_d   = sat_inc(turn_q);
        p_lat_d  = 1'b0;
        ai_lat_d = 1'b0;
      end
    end
  end

  always_comb begin
    p_move_ready  = (state_q == S_COLLECT) && !p_lat_q;
    ai_move_ready = (state_q == S_COLLECT) && !ai_lat_q;
    dmg_req       = (state_q == S_WAIT1) || (state_q == S_WAIT2);
    dmg_attacker  = 1'b0;
    dmg_move      = 2'd0;
    if (state_q == S_WAIT1 || state_q == S_APPLY1) begin
      dmg_attacker = !p_first_q;
      dmg_move     = p_first_q ? p_move_q : ai_move_q;
    end else if (state_q == S_WAIT2 || state_q == S_APPLY2) begin
      dmg_attacker = p_first_q;
      dmg_move     = p_first_q ? ai_move_q : p_move_q;
    end
    p_hp       = p_hp_q;
    ai_hp      = ai_hp_q;
    victory    = (state_q == S_VICTORY);
    loss       = (state_q == S_LOSS);
    turn_count = turn_q;
  end

endmodule

// File: tb/tb_battle_turn_sequencer.sv
// Directed bench for battle_turn_sequencer with a request scoreboard.
module tb_battle_turn_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       p_move_valid = 1'b0, ai_move_valid = 1'b0;
  logic [1:0] p_move = 2'd0, ai_move = 2'd0;
  logic       p_move_ready, ai_move_ready;
  logic [3:0] p_speed = 4'd0, ai_speed = 4'd0;
  logic       dmg_req, dmg_attacker;
  logic [1:0] dmg_move;
  logic       dmg_done = 1'b0;
  logic [3:0] dmg_value = 4'd0;
  logic [3:0] p_hp, ai_hp;
  logic       victory, loss;
  logic [7:0] turn_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] sb_q[$];

  battle_turn_sequencer #(.HP_W(4), .DMG_W(4), .SPD_W(4), .HP_INIT(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .p_move_valid(p_move_valid), .p_move(p_move), .p_move_ready(p_move_ready),
    .ai_move_valid(ai_move_valid), .ai_move(ai_move), .ai_move_ready(ai_move_ready),
    .p_speed(p_speed), .ai_speed(ai_speed),
    .dmg_req(dmg_req), .dmg_attacker(dmg_attacker), .dmg_move(dmg_move),
    .dmg_done(dmg_done), .dmg_value(dmg_value),
    .p_hp(p_hp), .ai_hp(ai_hp), .victory(victory), .loss(loss), .turn_count(turn_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    logic [2:0] e;
    while (dmg_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", dmg_req, 1);
    if (dmg_req === 1'b1) begin
      if (sb_q.size() == 0) chk("sb_underflow", 0, 1);
      else begin
        e = sb_q.pop_front();
        chk("req_attacker", dmg_attacker, e[2]);
        chk("req_move", dmg_move, e[1:0]);
      end
    end
  endtask

  task automatic serve(input logic [3:0] dmg);
    wait_req();
    dmg_done  = 1'b1;
    dmg_value = dmg;
    tick();
    dmg_done  = 1'b0;
    chk("req_drop", dmg_req, 0);
    tick();
  endtask

  task automatic offer_both(input logic [1:0] pm, input logic [1:0] am,
                            input logic [3:0] ps, input logic [3:0] as);
    p_move = pm; ai_move = am; p_speed = ps; ai_speed = as;
    p_move_valid = 1'b1; ai_move_valid = 1'b1;
    tick();
    p_move_valid = 1'b0; ai_move_valid = 1'b0;
    chk("latency_req", dmg_req, 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    // 1: basic turn, player faster
    do_reset();
    chk("rst_p_hp", p_hp, 15);
    chk("rst_ai_hp", ai_hp, 15);
    chk("rst_flags", {victory, loss, dmg_req}, 0);
    chk("rst_turn", turn_count, 0);
    chk("rst_ready", {p_move_ready, ai_move_ready}, 3);
    sb_q.push_back({1'b0, 2'd1});
    sb_q.push_back({1'b1, 2'd2});
    offer_both(2'd1, 2'd2, 4'd9, 4'd5);
    serve(4'd3);
    chk("t1_ai_hp", ai_hp, 12);
    chk("t1_p_hp_mid", p_hp, 15);
    serve(4'd3);
    chk("t1_p_hp", p_hp, 12);
    chk("t1_turn", turn_count, 1);
    chk("t1_ready", {p_move_ready, ai_move_ready}, 3);

    // 2: tie goes to player, zero damage; then AI faster
    sb_q.push_back({1'b0, 2'd3});
    sb_q.push_back({1'b1, 2'd0});
    offer_both(2'd3, 2'd0, 4'd7, 4'd7);
    serve(4'd0);
    serve(4'd0);
    chk("t2_hp", {p_hp, ai_hp}, {4'd12, 4'd12});
    chk("t2_turn", turn_count, 2);
    sb_q.push_back({1'b1, 2'd1});
    sb_q.push_back({1'b0, 2'd2});
    offer_both(2'd2, 2'd1, 4'd7, 4'd8);
    serve(4'd1);
    chk("t2b_p_hp", p_hp, 11);
    serve(4'd1);
    chk("t2b_hp", {p_hp, ai_hp}, {4'd11, 4'd11});
    chk("t2b_turn", turn_count, 3);

    // 3: AI move early, valid held high, single latch
    ai_move = 2'd3; ai_move_valid = 1'b1;
    tick();
    ai_move = 2'd1;
    for (int i = 0; i < 3; i++) tick();
    chk("t3_ready", {p_move_ready, ai_move_ready}, 2);
    chk("t3_noreq", dmg_req, 0);
    sb_q.push_back({1'b0, 2'd0});
    sb_q.push_back({1'b1, 2'd3});
    p_move = 2'd0; p_speed = 4'd6; ai_speed = 4'd4; p_move_valid = 1'b1;
    tick();
    p_move_valid = 1'b0;
    chk("t3_req_next", dmg_req, 1);
    serve(4'd2);
    ai_move_valid = 1'b0;
    serve(4'd2);
    chk("t3_hp", {p_hp, ai_hp}, {4'd9, 4'd9});
    chk("t3_turn", turn_count, 4);

    // 4: bring AI to 2, then lethal player hit and terminal hold
    sb_q.push_back({1'b0, 2'd1});
    sb_q.push_back({1'b1, 2'd2});
    offer_both(2'd1, 2'd2, 4'd3, 4'd3);
    serve(4'd7);
    serve(4'd0);
    chk("t4_ai_hp2", ai_hp, 2);
    chk("t4_turn5", turn_count, 5);
    sb_q.push_back({1'b0, 2'd2});
    offer_both(2'd2, 2'd0, 4'd10, 4'd2);
    serve(4'd5);
    chk("t4_victory", {victory, loss, ai_hp}, {1'b1, 1'b0, 4'd0});
    p_move_valid = 1'b1; ai_move_valid = 1'b1; dmg_done = 1'b1; dmg_value = 4'd4;
    for (int i = 0; i < 20; i++) begin
      chk("t4_hold", {victory, loss, dmg_req, p_move_ready, ai_move_ready, p_hp, ai_hp, turn_count},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 4'd0, 8'd5});
      tick();
    end
    p_move_valid = 1'b0; ai_move_valid = 1'b0; dmg_done = 1'b0;

    // 5: AI first, lethal 15 on player; reset recovers
    do_reset();
    chk("t5_rst_hp", {p_hp, ai_hp, victory}, {4'd15, 4'd15, 1'b0});
    sb_q.push_back({1'b1, 2'd2});
    offer_both(2'd1, 2'd2, 4'd2, 4'd9);
    serve(4'd15);
    chk("t5_loss", {loss, victory, p_hp, ai_hp, dmg_req}, {1'b1, 1'b0, 4'd0, 4'd15, 1'b0});
    tick();
    chk("t5_loss_hold", {loss, p_hp, turn_count}, {1'b1, 4'd0, 8'd0});
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("t5_recover", {loss, p_hp, ai_hp, p_move_ready, ai_move_ready}, {1'b0, 4'd15, 4'd15, 1'b1, 1'b1});

    // 6: spurious done in COLLECT, reset during WAIT2
    dmg_done = 1'b1; dmg_value = 4'd9;
    tick();
    tick();
    dmg_done = 1'b0;
    chk("t6_spurious", {p_hp, ai_hp, dmg_req}, {4'd15, 4'd15, 1'b0});
    sb_q.push_back({1'b0, 2'd1});
    sb_q.push_back({1'b1, 2'd2});
    offer_both(2'd1, 2'd2, 4'd5, 4'd1);
    serve(4'd4);
    chk("t6_ai_hp", ai_hp, 11);
    wait_req();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("t6_req_off", dmg_req, 0);
    chk("t6_state", {p_hp, ai_hp, turn_count}, {4'd15, 4'd15, 8'd0});
    chk("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
